uart_rcv: RTL
=============

// Module: uart_rcv
// PURPOSE
// - UART receiver paired with uart_trans: deserialises 8N1 bytes (LSB first) from USB_RX using
//   16x oversampling on uart_sampling_clk, buffers them in a small FIFO, presents them to the
//   core over a valid/ready port, and throttles the host with active-low USB_CTS.
// PARAMETERS
// - DEPTH      4   FIFO entries (power of 2, >= 2)
// - OSR        16  samples per bit; sample_count is $clog2(OSR) bits wide
// PORTS
// - uart_sampling_clk  in   1  sampling clock, OSR x baud
// - rst_n              in   1  reset, asynchronous, active-low
// - USB_RX             in   1  serial line from host; async, idle high
// - USB_CTS            out  1  0 = host may send; 1 = host must hold off
// - rx_data            out  8  FIFO head byte; valid only while rx_valid = 1
// - rx_valid           out  1  FIFO not empty
// - rx_ready           in   1  pop the head when rx_valid & rx_ready
// - framing_err        out  1  one-cycle pulse: stop bit sampled 0
// - overrun_err        out  1  one-cycle pulse: good byte dropped, FIFO full
// - cs_rcv             out  3  current FSM state, debug
// BEHAVIOUR
// - Reset: FSM s_idle, counters 0, FIFO empty, synchroniser flops 1, USB_CTS=1, error pulses 0,
//   cs_rcv=0. USB_CTS goes 0 on the first clock after rst_n rises.
// - USB_RX enters a 2-flop synchroniser (rx_s); all decisions use rx_s (2-cycle input latency).
// - States: s_idle=0, s_start=1, s_data=2, s_stop=3 (s_parity=4 with the macro).
// - s_idle: rx_s==0 -> s_start, sample_count=1. Otherwise hold, sample_count=0.
// - s_start: sample_count increments. At count OSR/2-1 (7): rx_s==1 -> false start, back to
//   s_idle, nothing recorded; rx_s==0 -> s_data, sample_count=0, bit_count=0.
// - s_data: at count OSR-1 (mid-bit), shift rx_s into bit 7 of the byte register (right shift,
//   LSB arrives first) and increment bit_count; the counter wraps to 0. After the 8th sample
//   -> s_stop (or s_parity).
// - s_stop: at count OSR-1, sample the stop bit. 1: push the byte if the FIFO is not full, else
//   pulse overrun_err. 0: pulse framing_err and discard the byte. Both cases -> s_idle the
//   same cycle, so a start bit right after the mid-stop sample is caught.
// - FIFO: push at the stop sample; rx_valid rises on the next clock. rx_data = head, no
//   bubble. Pop when rx_valid & rx_ready. Pop with rx_valid=0 is ignored.
// - Simultaneous push and pop: both take effect. When full, that push is accepted with no
//   overrun and the count is unchanged.
// - USB_CTS: registered, 1 when occupancy after this cycle's push/pop >= DEPTH-1, else 0.
//   The host keeps one slot of slack for a byte already in flight.
// - Reset mid-frame: immediate abort; the partial byte and FIFO contents are lost.
// - The line held low indefinitely gives a framing_err once, then s_start at each low idle
//   check. Stop-bit sampling does not re-arm on a level; it waits for the next falling edge
//   only after rx_s returns to 1.
// CONFIGURATION
// - UART_RX_PARITY_EN defined: 8E1 frames. After the 8 data bits, s_parity samples the parity
//   bit at count OSR-1. At the stop sample, a parity mismatch (even parity over data plus
//   parity bit) pulses the added output parity_err and discards the byte. Framing is checked
//   first: if both fail, only framing_err pulses.
// - Macro undefined: 8N1, no s_parity state, no parity_err port.
// TESTING
// - 0xAA, 16 clk/bit, rx_ready=1 -> rx_valid for 1 cycle with rx_data=0xAA, 1 clk after the
//   stop sample; no error pulses.
// - 0xCC then 0x3C back-to-back, stop bit only to mid-bit -> both bytes received in order.
// - USB_RX low for 5 clocks then high -> false start; s_idle, no push, no error.
// - 0x55 with stop bit 0 -> framing_err pulse; rx_valid stays 0.
// - rx_ready=0, DEPTH=4: send 5 bytes -> USB_CTS=1 after byte 3, byte 5 gives overrun_err,
//   bytes 1-4 pop intact. Pop exactly at a stop sample while full -> no overrun.
// - rst_n low during bit 4 -> outputs at reset values. Next full frame 0x81 received
//   correctly. With UART_RX_PARITY_EN, 0x81 with parity bit 1 -> parity_err, no push.

Source files
------------

// File: rtl/uart_rcv.sv
// UART 8N1 receiver with 16x oversampling, small receive FIFO and active-low CTS flow control.
// Define UART_RX_PARITY_EN for 8E1 frames with an added parity_err output.
module uart_rcv #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned OSR   = 16
) (
    input  logic       uart_sampling_clk,
    input  logic       rst_n,
    input  logic       USB_RX,
    output logic       USB_CTS,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       framing_err,
    output logic       overrun_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic [2:0] cs_rcv
);

    localparam int unsigned CW = $clog2(OSR);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = PW + 1;
    localparam logic [CW-1:0] MID_START = CW'(OSR / 2 - 1);
    localparam logic [CW-1:0] MID_BIT   = CW'(OSR - 1);

    typedef enum logic [2:0] {
        s_idle   = 3'd0,
        s_start  = 3'd1,
        s_data   = 3'd2,
        s_stop   = 3'd3
`ifdef UART_RX_PARITY_EN
        ,
        s_parity = 3'd4
`endif
    } state_t;

    state_t          state;
    logic            rx_meta;
    logic            rx_s;
    logic [CW-1:0]   sample_count;
    logic [2:0]      bit_count;
    logic [7:0]      shift_reg;
    logic            line_break;
`ifdef UART_RX_PARITY_EN
    logic            parity_bit;
`endif

    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [OW-1:0]   count;
    logic [OW-1:0]   count_nxt;

    logic            stop_sample_c;
    logic            byte_ok_c;
    logic            push_c;
    logic            pop_c;
    logic            full_c;
    logic            wr_en_c;

    assign cs_rcv  = state;
    assign rx_data = mem[rd_ptr];

    // Two-flop synchroniser for the asynchronous serial line
    always_ff @(posedge uart_sampling_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= USB_RX;
            rx_s    <= rx_meta;
        end
    end

    // Frame sequencer; line_break blocks a new frame until the line has gone high after a framing error
    always_ff @(posedge uart_sampling_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= s_idle;
            sample_count <= '0;
            bit_count    <= '0;
            shift_reg    <= '0;
            line_break   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit   <= 1'b0;
`endif
        end else begin
            if (rx_s) begin
                line_break <= 1'b0;
            end
            case (state)
                s_idle: begin
                    if (!rx_s) begin
                        state        <= s_start;
                        sample_count <= CW'(1);
                    end else begin
                        sample_count <= '0;
                    end
                end
                s_start: begin
                    if (sample_count == MID_START) begin
                        sample_count <= '0;
                        bit_count    <= '0;
                        if (rx_s || line_break) begin
                            state <= s_idle;
                        end else begin
                            state <= s_data;
                        end
                    end else begin
                        sample_count <= sample_count + CW'(1);
                    end
                end
                s_data: begin
                    if (sample_count == MID_BIT) begin
                        sample_count <= '0;
                        shift_reg    <= {rx_s, shift_reg[7:1]};
                        bit_count    <= bit_count + 3'd1;
                        if (bit_count == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= s_parity;
`else
                            state <= s_stop;
`endif
                        end
                    end else begin
                        sample_count <= sample_count + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                s_parity: begin
                    if (sample_count == MID_BIT) begin
                        sample_count <= '0;
                        parity_bit   <= rx_s;
                        state        <= s_stop;
                    end else begin
                        sample_count <= sample_count + CW'(1);
                    end
                end
`endif
                s_stop: begin
                    if (sample_count == MID_BIT) begin
                        sample_count <= '0;
                        state        <= s_idle;
                        if (!rx_s) begin
                            line_break <= 1'b1;
                        end
                    end else begin
                        sample_count <= sample_count + CW'(1);
                    end
                end
                default: begin
                    state        <= s_idle;
                    sample_count <= '0;
                end
            endcase
        end
    end

    // Push/pop decisions; a pop in the same cycle frees the slot a full-FIFO push needs
    always_comb begin
        stop_sample_c = (state == s_stop) && (sample_count == MID_BIT);
`ifdef UART_RX_PARITY_EN
        byte_ok_c     = rx_s && !(^{shift_reg, parity_bit});
`else
        byte_ok_c     = rx_s;
`endif
        push_c        = stop_sample_c && byte_ok_c;
        pop_c         = rx_valid && rx_ready;
        full_c        = (count == OW'(DEPTH));
        wr_en_c       = push_c && (!full_c || pop_c);
        count_nxt     = count + OW'(wr_en_c) - OW'(pop_c);
    end

    always_ff @(posedge uart_sampling_clk) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= shift_reg;
        end
    end

    always_ff @(posedge uart_sampling_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rx_valid    <= 1'b0;
            USB_CTS     <= 1'b1;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count       <= count_nxt;
            rx_valid    <= (count_nxt != '0);
            USB_CTS     <= (count_nxt >= OW'(DEPTH - 1));
            framing_err <= stop_sample_c && !rx_s;
            overrun_err <= push_c && full_c && !pop_c;
`ifdef UART_RX_PARITY_EN
            parity_err  <= stop_sample_c && rx_s && (^{shift_reg, parity_bit});
`endif
        end
    end

endmodule
